// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a big-endian byte stream into 32-bit word writes and holds the core until the image is in.
// Optional trailer checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CAP = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [15:0] len_q;
  logic [15:0] len_n;
  logic        accept;
  logic        last_word;
  logic        enter_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept    = rx_valid & rx_ready;
  assign len_n     = {len_q[15:8], rx_data};
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len_q);
  assign enter_len = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LEN;
      S_LEN: begin
        if (accept && byte_cnt[0]) begin
          if (len_n == 16'd0)           state_next = S_FIN;
          else if (32'(len_n) > CAP)    state_next = S_ERR;
          else                          state_next = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_FIN : S_DATA;
      S_DONE:  if (start) state_next = S_LEN;
      S_ERR:   if (start) state_next = S_LEN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:   if (accept) state_next = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Status and handshake outputs track the state being entered so they line up with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_ready  <= 1'b0;
      imem_we   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      rx_ready  <= (state_next == S_LEN) | (state_next == S_DATA) | (state_next == S_CHK);
`else
      rx_ready  <= (state_next == S_LEN) | (state_next == S_DATA);
`endif
      imem_we   <= (state_next == S_WRITE);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERR);
      core_hold <= (state_next != S_DONE);
    end
  end

  // Length capture, word assembly and write index.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_cnt     <= 2'd0;
      len_q        <= 16'd0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else if (enter_len) begin
      byte_cnt     <= 2'd0;
      imem_addr    <= '0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      case (state)
        S_LEN: begin
          if (accept) begin
            if (!byte_cnt[0]) begin
              len_q[15:8] <= rx_data;
              byte_cnt    <= 2'd1;
            end else begin
              len_q[7:0]  <= rx_data;
              byte_cnt    <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            imem_wdata <= {imem_wdata[23:0], rx_data};
            byte_cnt   <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          // Index stays on the final address so it never wraps.
          if (!last_word) imem_addr <= imem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
